// File: rtl/countdown_timer_ctrl.sv
// Game-clock countdown controller: holds a seconds.tenths count, gates the shared
// 100 ms tick generator and flags warning / time-up. Commands are one-cycle pulses.
module countdown_timer_ctrl #(
  parameter int SEC_W       = 7,
  parameter int MAX_SEC     = 99,
  parameter int DEFAULT_SEC = 60,
  parameter int WARN_SEC    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             tick_100ms,
  output logic             timer_enable,
  output logic [SEC_W-1:0] sec_remaining,
  output logic [3:0]       tenths,
  output logic             running,
  output logic             warning,
  output logic             time_up
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [3:0]       tenths_q, tenths_d;
  logic             timer_enable_q, timer_enable_d;
  logic             warning_q, warning_d;
  logic             time_up_q, time_up_d;
  logic             expire;
  logic [SEC_W-1:0] load_clamped;
  logic             count_zero;

  assign load_clamped = (load_sec > SEC_W'(MAX_SEC)) ? SEC_W'(MAX_SEC) : load_sec;
  assign count_zero   = (sec_q == '0) && (tenths_q == 4'd0);

  // State and count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sec_q          <= SEC_W'(DEFAULT_SEC);
      tenths_q       <= 4'd0;
      timer_enable_q <= 1'b0;
      warning_q      <= 1'b0;
      time_up_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sec_q          <= sec_d;
      tenths_q       <= tenths_d;
      timer_enable_q <= timer_enable_d;
      warning_q      <= warning_d;
      time_up_q      <= time_up_d;
    end
  end

  // Next state: the highest-priority command present wins the cycle, even when
  // the current state ignores it; a tick is only honoured with no command at all.
  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    tenths_d = tenths_q;
    expire   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else if (load) begin
      if (state_q != S_RUN) begin
        sec_d    = load_clamped;
        tenths_d = 4'd0;
        state_d  = (state_q == S_PAUSE) ? S_PAUSE : S_IDLE;
      end
    end else if (start) begin
      if (state_q == S_IDLE || state_q == S_PAUSE) begin
        if (count_zero) begin
          state_d = S_DONE;
          expire  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
    end else if (pause) begin
      if (state_q == S_RUN) begin
        state_d = S_PAUSE;
      end else if (state_q == S_PAUSE) begin
        state_d = S_RUN;
      end
    end else if (tick_100ms && state_q == S_RUN) begin
      if (tenths_q != 4'd0) begin
        tenths_d = tenths_q - 4'd1;
      end else if (sec_q != '0) begin
        tenths_d = 4'd9;
        sec_d    = sec_q - SEC_W'(1);
      end
      if (sec_d == '0 && tenths_d == 4'd0) begin
        state_d = S_DONE;
        expire  = 1'b1;
      end
    end
  end

  // Outputs are registered from the next-state values so they line up with state_q
  always_comb begin
    timer_enable_d = (state_d == S_RUN);
    warning_d      = ((state_d == S_RUN) || (state_d == S_PAUSE)) &&
                     (sec_d < SEC_W'(WARN_SEC));
    time_up_d      = expire;
  end

  assign timer_enable  = timer_enable_q;
  assign running       = timer_enable_q;
  assign warning       = warning_q;
  assign time_up       = time_up_q;
  assign sec_remaining = sec_q;
  assign tenths        = tenths_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed scenarios plus random command traffic,
// all checked cycle by cycle against a total-tenths reference model.
module tb_countdown_timer_ctrl;

  localparam int SEC_W = 7;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [SEC_W-1:0] load_sec;
  logic             start;
  logic             pause;
  logic             abort;
  logic             tick_100ms;
  logic             timer_enable;
  logic [SEC_W-1:0] sec_remaining;
  logic [3:0]       tenths;
  logic             running;
  logic             warning;
  logic             time_up;

  int n_vec = 0;
  int n_err = 0;
  int tu_seen;

  // Reference model: count kept as a single number of tenths
  int m_mode;
  int m_cnt;
  bit m_tu;

  countdown_timer_ctrl #(
    .SEC_W(SEC_W), .MAX_SEC(99), .DEFAULT_SEC(60), .WARN_SEC(10)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .load_sec(load_sec), .start(start),
    .pause(pause), .abort(abort), .tick_100ms(tick_100ms),
    .timer_enable(timer_enable), .sec_remaining(sec_remaining), .tenths(tenths),
    .running(running), .warning(warning), .time_up(time_up)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cnt  = 600;
    m_tu   = 1'b0;
  endtask

  task automatic model_step(input bit ab, input bit ld, input int ls,
                            input bit st, input bit ps, input bit tk);
    m_tu = 1'b0;
    if (ab) begin
      m_mode = M_IDLE;
    end else if (ld) begin
      if (m_mode != M_RUN) begin
        m_cnt = ((ls > 99) ? 99 : ls) * 10;
        if (m_mode == M_DONE) m_mode = M_IDLE;
      end
    end else if (st) begin
      if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
        if (m_cnt == 0) begin
          m_mode = M_DONE;
          m_tu   = 1'b1;
        end else begin
          m_mode = M_RUN;
        end
      end
    end else if (ps) begin
      if (m_mode == M_RUN) m_mode = M_PAUSE;
      else if (m_mode == M_PAUSE) m_mode = M_RUN;
    end else if (tk && m_mode == M_RUN) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_mode = M_DONE;
        m_tu   = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    bit act;
    act = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    check("sec_remaining", sec_remaining, m_cnt / 10);
    check("tenths", tenths, m_cnt % 10);
    check("timer_enable", timer_enable, m_mode == M_RUN);
    check("running", running, m_mode == M_RUN);
    check("warning", warning, act && (m_cnt / 10 < 10));
    check("time_up", time_up, m_tu);
    if (time_up === 1'b1) tu_seen++;
  endtask

  // One clock: drive at the falling edge, model at the rising edge, sample 1 ns later
  task automatic cycle(input bit ab, input bit ld, input int ls,
                       input bit st, input bit ps, input bit tk);
    abort      = ab;
    load       = ld;
    load_sec   = SEC_W'(ls);
    start      = st;
    pause      = ps;
    tick_100ms = tk;
    @(posedge clk);
    model_step(ab, ld, ls, st, ps, tk);
    #1;
    check_outputs();
    @(negedge clk);
    abort = 0; load = 0; start = 0; pause = 0; tick_100ms = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    abort = 0; load = 0; load_sec = '0; start = 0; pause = 0; tick_100ms = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cmd;
    int ls;
    tu_seen = 0;
    do_reset();

    // 3.0 down to 0.0 with a tick every 10 cycles
    cycle(0, 1, 3, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check("warn_from_start", warning, 1);
    tu_seen = 0;
    for (int t = 1; t <= 30; t++) begin
      idle(9);
      cycle(0, 0, 0, 0, 0, 1);
      if (t == 29) check("tu_before_30th", tu_seen, 0);
    end
    check("tu_on_30th", time_up, 1);
    idle(5);
    check("tu_single_pulse", tu_seen, 1);
    check("done_enable_off", timer_enable, 0);

    // Clamp on load, then a single tick from 99.0
    cycle(0, 1, 120, 0, 0, 0);
    check("clamp_sec", sec_remaining, 99);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("after_tick_sec", sec_remaining, 98);
    check("after_tick_tenths", tenths, 9);

    // 12.0, 25 ticks, pause holds, resume continues
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 12, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    for (int t = 0; t < 25; t++) cycle(0, 0, 0, 0, 0, 1);
    check("run25_sec", sec_remaining, 9);
    check("run25_tenths", tenths, 5);
    cycle(0, 0, 0, 0, 1, 0);
    for (int t = 0; t < 5; t++) cycle(0, 0, 0, 0, 0, 1);
    check("paused_tenths", tenths, 5);
    check("paused_enable", timer_enable, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("resumed_tenths", tenths, 4);

    // Simultaneous commands
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 5, 1, 0, 0);
    check("load_beats_start", sec_remaining, 5);
    check("load_beats_start_idle", running, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 1);
    check("abort_beats_tick", tenths, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 20, 0, 0, 0);
    check("load_in_run_ignored", sec_remaining, 5);

    // Zero count start goes straight to DONE
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    tu_seen = 0;
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    idle(2);
    check("zero_start_one_pulse", tu_seen, 1);

    // Asynchronous reset between clock edges while running
    cycle(0, 1, 20, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    for (int t = 0; t < 3; t++) cycle(0, 0, 0, 0, 0, 1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    tu_seen = 0;
    idle(3);
    check("no_residual_tu", tu_seen, 0);

    // Random traffic, at most one command per cycle plus an optional tick
    for (int i = 0; i < 3000; i++) begin
      cmd = $urandom_range(0, 15);
      ls  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 2);
      cycle(cmd == 0, cmd inside {[1:2]}, ls, cmd inside {[3:5]}, cmd inside {[6:7]},
            $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
